// File: rtl/fa_serial_sched.sv
// Round-robin front end for one shared full-adder cell. Each granted request
// is summed bit-serially, LSB first, with the ripple carry held in a flop.
module fa_serial_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NREQ-1:0]                              req_valid,
    output logic [NREQ-1:0]                              req_ready,
    input  logic [NREQ*WIDTH-1:0]                        req_a,
    input  logic [NREQ*WIDTH-1:0]                        req_b,
    input  logic [NREQ-1:0]                              req_cin,
    output logic                                         fa_a,
    output logic                                         fa_b,
    output logic                                         fa_ci,
    input  logic                                         fa_s,
    input  logic                                         fa_co,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]   rsp_id,
    output logic [WIDTH-1:0]                             rsp_sum,
    output logic                                         rsp_cout,
    output logic                                         busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [IW-1:0]    id_q,    id_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] opa_q,   opa_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;

    logic [NREQ-1:0]  gnt_c;
    logic [IW-1:0]    gnt_idx_c;
    logic             gnt_any_c;

    // First valid requester at or above ptr, wrapping to 0.
    always_comb begin : rr_grant
        int unsigned idx;
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any_c && req_valid[IW'(idx)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IW'(idx);
            end
        end
        gnt_c[gnt_idx_c] = gnt_any_c;
    end

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any_c) begin
                    opa_d   = req_a[32'(gnt_idx_c)*WIDTH +: WIDTH];
                    opb_d   = req_b[32'(gnt_idx_c)*WIDTH +: WIDTH];
                    carry_d = req_cin[gnt_idx_c];
                    id_d    = gnt_idx_c;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits arrive LSB first and shift down from the MSB.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Grant is masked while reset is held so nothing is offered before release.
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? gnt_c : '0;

    assign fa_a      = (state_q == ST_RUN) & opa_q[0];
    assign fa_b      = (state_q == ST_RUN) & opb_q[0];
    assign fa_ci     = (state_q == ST_RUN) & carry_q;

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_sum   = (state_q == ST_DONE) ? sum_q : '0;
    assign rsp_cout  = (state_q == ST_DONE) & carry_q;
    assign rsp_id    = (state_q == ST_DONE) ? id_q : '0;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_fa_serial_sched.sv
// Directed and randomized bench for fa_serial_sched with a behavioural full adder.
module tb_fa_serial_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_cin = '0;
    logic                  fa_a, fa_b, fa_ci, fa_s, fa_co;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;

    fa_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ci     (fa_ci),
        .fa_s      (fa_s),
        .fa_co     (fa_co),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Full-adder cell: sum is parity, carry is majority.
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = c;
        req_valid[i]            = 1'b1;
    endtask

    function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
        return 9'(a) + 9'(b) + 9'(c);
    endfunction

    function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (v[j]) return 4'(1) << j;
        end
        return 4'b0000;
    endfunction

    task automatic wait_rsp(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (rsp_valid) ok = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        #3;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if ({fa_a, fa_b, fa_ci} !== 3'b000) begin miscompares++; $display("FAIL reset_fa: got %b expected 000", {fa_a, fa_b, fa_ci}); end
        vectors++; if ({rsp_cout, rsp_sum, rsp_id} !== 11'd0) begin miscompares++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp_cout, rsp_sum, rsp_id}); end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] av = 8'h5A;
        logic [7:0] bv = 8'h33;
        set_req(2, av, bv, 1'b0);
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready_run: got %b expected 0000", req_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int c = 0; c < WIDTH; c++) begin
            vectors++; if (fa_a !== av[c]) begin miscompares++; $display("FAIL single_fa_a[%0d]: got %b expected %b", c, fa_a, av[c]); end
            vectors++; if (fa_b !== bv[c]) begin miscompares++; $display("FAIL single_fa_b[%0d]: got %b expected %b", c, fa_b, bv[c]); end
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid[%0d]: got %b expected 0", c, rsp_valid); end
            tick();
        end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
        vectors++; if (rsp_sum !== 8'h8D) begin miscompares++; $display("FAIL single_sum: got %h expected 8d", rsp_sum); end
        vectors++; if (rsp_cout !== 1'b0) begin miscompares++; $display("FAIL single_cout: got %b expected 0", rsp_cout); end
        vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++; if ({rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL single_idle: got %b expected 00", {rsp_valid, busy}); end
    endtask

    task automatic test_carry();
        logic [7:0] ta [2] = '{8'hFF, 8'hFF};
        logic [7:0] tb [2] = '{8'h01, 8'hFF};
        logic       tc [2] = '{1'b0, 1'b1};
        logic [8:0] ts [2] = '{9'h100, 9'h1FF};
        for (int t = 0; t < 2; t++) begin
            set_req(0, ta[t], tb[t], tc[t]);
            #1;
            vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL carry_grant[%0d]: got %b expected 0001", t, req_ready); end
            tick();
            req_valid = '0;
            for (int c = 0; c < WIDTH; c++) begin
                logic exp_ci;
                exp_ci = (c == 0) ? tc[t] : 1'b1;
                vectors++; if (fa_ci !== exp_ci) begin miscompares++; $display("FAIL carry_fa_ci[%0d][%0d]: got %b expected %b", t, c, fa_ci, exp_ci); end
                tick();
            end
            vectors++; if ({rsp_valid, rsp_cout, rsp_sum} !== {1'b1, ts[t]}) begin
                miscompares++; $display("FAIL carry_result[%0d]: got %h expected %h", t, {rsp_valid, rsp_cout, rsp_sum}, {1'b1, ts[t]});
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_fairness();
        logic [7:0] fa [4] = '{8'h11, 8'h22, 8'hC3, 8'hF4};
        logic [7:0] fb [4] = '{8'h0F, 8'hE1, 8'h7E, 8'h9C};
        logic       fc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int  cyc;
        bit  ok;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, fa[i], fb[i], fc[i]);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 6; n++) begin
            int id;
            id = n % NREQ;
            vectors++; if (req_ready !== 4'(4'(1) << id)) begin miscompares++; $display("FAIL fair_grant[%0d]: got %b expected %b", n, req_ready, 4'(4'(1) << id)); end
            tick();
            wait_rsp(cyc, ok);
            vectors++; if (!ok || cyc != WIDTH) begin miscompares++; $display("FAIL fair_latency[%0d]: got %0d cycles (seen=%0d) expected %0d", n, cyc, ok, WIDTH); end
            vectors++; if (rsp_id !== 2'(id)) begin miscompares++; $display("FAIL fair_id[%0d]: got %0d expected %0d", n, rsp_id, id); end
            vectors++; if ({rsp_cout, rsp_sum} !== ref_add(fa[id], fb[id], fc[id])) begin
                miscompares++; $display("FAIL fair_result[%0d]: got %h expected %h", n, {rsp_cout, rsp_sum}, ref_add(fa[id], fb[id], fc[id]));
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [8:0] exp = ref_add(8'hA7, 8'h6C, 1'b1);
        int  cyc;
        bit  ok;
        set_req(3, 8'hA7, 8'h6C, 1'b1);
        set_req(1, 8'h55, 8'h0A, 1'b0);
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
        tick();
        wait_rsp(cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got no rsp_valid expected one within 40 cycles"); end
        for (int k = 0; k < 5; k++) begin
            vectors++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {1'b1, exp, 2'd3}) begin
                miscompares++; $display("FAIL bp_rsp[%0d]: got %h expected %h", k, {rsp_valid, rsp_cout, rsp_sum, rsp_id}, {1'b1, exp, 2'd3});
            end
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b expected 0000", k, req_ready); end
            vectors++; if ({fa_a, fa_b, fa_ci, busy} !== 4'b0001) begin miscompares++; $display("FAIL bp_fa_busy[%0d]: got %b expected 0001", k, {fa_a, fa_b, fa_ci, busy}); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b expected 0", rsp_valid); end
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_next_grant: got %b expected 0010", req_ready); end
        req_valid = '0;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_drop_ready: got %b expected 0000", req_ready); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_drop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] exp = ref_add(8'h3C, 8'h45, 1'b1);
        int  cyc;
        bit  ok;
        set_req(1, 8'h3C, 8'h45, 1'b1);
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_grant: got %b expected 0010", req_ready); end
        tick();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({busy, rsp_valid, fa_a, fa_b, fa_ci} !== 5'b0) begin miscompares++; $display("FAIL mid_async: got %b expected 00000", {busy, rsp_valid, fa_a, fa_b, fa_ci}); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
        tick();
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid); end
        rst_n = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_regrant: got %b expected 0010", req_ready); end
        tick();
        wait_rsp(cyc, ok);
        vectors++; if (!ok || cyc != WIDTH) begin miscompares++; $display("FAIL mid_latency: got %0d cycles (seen=%0d) expected %0d", cyc, ok, WIDTH); end
        vectors++; if ({rsp_id, rsp_cout, rsp_sum} !== {2'd1, exp}) begin miscompares++; $display("FAIL mid_result: got %h expected %h", {rsp_id, rsp_cout, rsp_sum}, {2'd1, exp}); end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int         waits [NREQ];
        int         exp_ptr = 0;
        int         ops     = 0;
        int         cycles  = 0;
        int         since   = 0;
        int         pend_id = 0;
        logic [8:0] pend_res = '0;
        bit         mbusy   = 1'b0;
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        while (ops < 2000 && cycles < 60000) begin
            bit granted   = 1'b0;
            bit handshake = 1'b0;
            int gidx      = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
                        waits[i] = 0;
                    end
                end else if (!mbusy && $urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            vectors++; if (busy !== mbusy) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b expected %b", cycles, busy, mbusy); end
            if (mbusy) begin
                vectors++; if (rsp_valid !== (since >= WIDTH)) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cycles, rsp_valid, since >= WIDTH); end
                if (rsp_valid && rsp_ready) begin
                    handshake = 1'b1;
                    vectors++; if ({rsp_id, rsp_cout, rsp_sum} !== {2'(pend_id), pend_res}) begin
                        miscompares++; $display("FAIL rnd_result[%0d]: got %h expected %h", ops, {rsp_id, rsp_cout, rsp_sum}, {2'(pend_id), pend_res});
                    end
                end
            end else begin
                logic [3:0] eg;
                eg = rr_pick(req_valid, exp_ptr);
                vectors++; if (req_ready !== eg) begin miscompares++; $display("FAIL rnd_grant[%0d]: got %b expected %b", cycles, req_ready, eg); end
                if (eg != 4'b0000) begin
                    for (int i = 0; i < NREQ; i++) if (eg[i]) gidx = i;
                    vectors++; if (waits[gidx] > NREQ - 1) begin miscompares++; $display("FAIL rnd_starve[%0d]: got %0d grants waited expected <= %0d", gidx, waits[gidx], NREQ - 1); end
                    for (int i = 0; i < NREQ; i++) if (req_valid[i] && i != gidx) waits[i]++;
                    granted  = 1'b1;
                    pend_id  = gidx;
                    pend_res = ref_add(req_a[gidx*WIDTH +: WIDTH], req_b[gidx*WIDTH +: WIDTH], req_cin[gidx]);
                end
            end
            tick();
            cycles++;
            since++;
            if (granted) begin
                req_valid[gidx] = 1'b0;
                mbusy = 1'b1;
                since = 0;
            end
            if (handshake) begin
                mbusy   = 1'b0;
                exp_ptr = (pend_id + 1) % NREQ;
                ops++;
            end
            if (mbusy && since > 200) begin
                $display("FAIL rnd_timeout: got no response after %0d cycles expected one", since);
                miscompares++;
                break;
            end
        end
        vectors++; if (ops < 2000) begin miscompares++; $display("FAIL rnd_ops: got %0d completed expected 2000", ops); end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_fairness();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
